// File: rtl/airi5c_shifter_pipe_if.sv
// Operand/result bus of the pipelined barrel shifter: upstream valid/ready in,
// downstream valid/ready out, plus the flush strobe.
interface airi5c_shifter_pipe_if #(
    parameter int n = 32,
    parameter int s = 5
);
    logic         kill;
    logic         valid_in;
    logic         ready_out;
    logic [n-1:0] in;
    logic [s-1:0] sel;
    logic         dir;
    logic         sgn;
    logic         valid_out;
    logic         ready_in;
    logic [n-1:0] out;
    logic         sticky_bit;

    modport master (
        output kill, valid_in, in, sel, dir, sgn, ready_in,
        input  ready_out, valid_out, out, sticky_bit
    );

    modport slave (
        input  kill, valid_in, in, sel, dir, sgn, ready_in,
        output ready_out, valid_out, out, sticky_bit
    );
endinterface

// File: rtl/airi5c_shifter_pipe.sv
// Pipelined bidirectional barrel shifter with sticky (lost-bit) output,
// valid/ready flow control and a synchronous kill.
module airi5c_shifter_pipe #(
    parameter int n      = 32,
    parameter int s      = 5,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    airi5c_shifter_pipe_if.slave  bus
);
    localparam int G = (s + STAGES - 1) / STAGES;

    // Applies log levels lo..hi-1. Every register stage carries the full sel, so
    // the lower sel bits tell how many fill bits already sit at the top of a right
    // shift; those are masked out of the sticky so sign fill never counts as lost.
    function automatic logic [n:0] shift_grp(input logic [n-1:0] d_in, input logic [s-1:0] sl,
                                             input logic dr, input logic sg, input int lo, input int hi);
        logic [n-1:0] d, keep, lmask;
        logic         lost;
        int           amt, filled;
        d      = d_in;
        lost   = 1'b0;
        filled = 0;
        for (int i = 0; i < s; i++) begin
            amt = 1 << i;
            if (i >= lo && i < hi && sl[i]) begin
                keep = (dr || filled == 0) ? '1 : (filled >= n) ? '0 : ({n{1'b1}} >> filled);
                if (amt >= n) begin
                    lost = lost | (|(d & keep));
                    d    = dr ? '0 : {n{sg}};
                end else if (dr) begin
                    lost = lost | (|(d >> (n - amt)));
                    d    = d << amt;
                end else begin
                    lmask = ~({n{1'b1}} << amt);
                    lost  = lost | (|(d & keep & lmask));
                    d     = (d >> amt) | ({n{sg}} << (n - amt));
                end
            end
            if (sl[i]) filled = filled + amt;
        end
        return {lost, d};
    endfunction

    logic [STAGES-1:0]        r_vld, r_dir, r_sgn, r_sticky;
    logic [STAGES-1:0][n-1:0] r_data;
    logic [STAGES-1:0][s-1:0] r_sel;

    logic [STAGES-1:0]        w_adv, w_vld_in, w_dir_in, w_sgn_in, w_st_in, w_st_nx;
    logic [STAGES-1:0][n-1:0] w_d_in, w_d_nx;
    logic [STAGES-1:0][s-1:0] w_sel_in;

    // A stage may load when it, or any stage after it, has a hole, or the sink takes the output.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = bus.ready_in;
            for (int j = k; j < STAGES; j++)
                if (!r_vld[j]) w_adv[k] = 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * G;
            localparam int HI = ((k + 1) * G < s) ? (k + 1) * G : s;
            logic w_lost;

            if (k == 0) begin : g_head
                assign w_d_in[k]   = bus.in;
                assign w_sel_in[k] = bus.sel;
                assign w_dir_in[k] = bus.dir;
                assign w_sgn_in[k] = bus.sgn;
                assign w_st_in[k]  = 1'b0;
                assign w_vld_in[k] = bus.valid_in;
            end else begin : g_body
                assign w_d_in[k]   = r_data[k-1];
                assign w_sel_in[k] = r_sel[k-1];
                assign w_dir_in[k] = r_dir[k-1];
                assign w_sgn_in[k] = r_sgn[k-1];
                assign w_st_in[k]  = r_sticky[k-1];
                assign w_vld_in[k] = r_vld[k-1];
            end

            assign {w_lost, w_d_nx[k]} = shift_grp(w_d_in[k], w_sel_in[k], w_dir_in[k], w_sgn_in[k], LO, HI);
            assign w_st_nx[k] = w_st_in[k] | w_lost;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_vld    <= '0;
            r_dir    <= '0;
            r_sgn    <= '0;
            r_sticky <= '0;
            r_data   <= '0;
            r_sel    <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.kill)
                    r_vld[k] <= 1'b0;
                else if (w_adv[k])
                    r_vld[k] <= w_vld_in[k];
                if (w_adv[k]) begin
                    r_data[k]   <= w_d_nx[k];
                    r_sel[k]    <= w_sel_in[k];
                    r_dir[k]    <= w_dir_in[k];
                    r_sgn[k]    <= w_sgn_in[k];
                    r_sticky[k] <= w_st_nx[k];
                end
            end
        end
    end

    assign bus.ready_out  = w_adv[0] & ~bus.kill;
    assign bus.valid_out  = r_vld[STAGES-1];
    assign bus.out        = r_data[STAGES-1];
    assign bus.sticky_bit = r_sticky[STAGES-1];

    // Control fields of the final stage have no consumer.
    logic w_unused;
    assign w_unused = ^{r_sel[STAGES-1], r_dir[STAGES-1], r_sgn[STAGES-1]};
endmodule

// File: tb/tb_airi5c_shifter_pipe.sv
// Bench for airi5c_shifter_pipe: arithmetic reference model + scoreboard checked
// every cycle, directed literal vectors, back-pressure, kill, async reset, random sweep.
module tb_airi5c_shifter_pipe;
    localparam int N  = 8;
    localparam int S  = 3;
    localparam int ST = 2;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    airi5c_shifter_pipe_if #(.n(N), .s(S)) b1();
    airi5c_shifter_pipe_if #(.n(5), .s(3)) b2();

    airi5c_shifter_pipe #(.n(N), .s(S), .STAGES(ST)) dut (.clk(clk), .n_reset(n_reset), .bus(b1.slave));
    airi5c_shifter_pipe #(.n(5), .s(3), .STAGES(3))  dut5 (.clk(clk), .n_reset(n_reset), .bus(b2.slave));

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_out = 0;
    bit         chk_en = 1'b0;
    logic [8:0] q[$];
    logic       prev_stall = 1'b0;
    logic [N-1:0] prev_out = '0;
    logic       prev_st = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: shift a zero-extended w-bit operand in a 64-bit word; right shifts
    // pre-load the fill above bit w. Sticky = any operand bit that leaves the window.
    function automatic logic [8:0] mdl(input int w, input logic [7:0] x, input logic [2:0] sh,
                                       input logic d, input logic sg);
        longint unsigned m, v, r;
        logic st;
        m = (64'd1 << w) - 64'd1;
        v = 64'(x) & m;
        if (d) begin
            r  = v << sh;
            st = |(r >> w);
        end else begin
            st = |(v & ((64'd1 << sh) - 64'd1));
            if (sg) v = v | ~m;
            r = v >> sh;
        end
        r = r & m;
        return {st, r[7:0]};
    endfunction

    always @(negedge n_reset) begin
        q.delete();
        prev_stall = 1'b0;
    end

    // Per-cycle comparison of DUT b1 against the scoreboard; transfers are decided
    // here (inputs are stable from posedge+1 until the next posedge).
    always @(negedge clk) begin
        logic       exp_rdy;
        logic [8:0] e;
        if (n_reset && chk_en) begin
            exp_rdy = !b1.kill && (q.size() < ST || b1.ready_in);
            chk("ready_out", 32'(b1.ready_out), 32'(exp_rdy));
            if (prev_stall) begin
                chk("hold_valid", 32'(b1.valid_out), 32'd1);
                chk("hold_out", 32'(b1.out), 32'(prev_out));
                chk("hold_sticky", 32'(b1.sticky_bit), 32'(prev_st));
            end
            if (q.size() == 0)
                chk("idle_valid", 32'(b1.valid_out), 32'd0);
            else if (b1.valid_out) begin
                e = q[0];
                chk("out", 32'(b1.out), 32'(e[7:0]));
                chk("sticky", 32'(b1.sticky_bit), 32'(e[8]));
            end
            prev_stall = b1.valid_out && !b1.ready_in && !b1.kill;
            prev_out   = b1.out;
            prev_st    = b1.sticky_bit;
            if (b1.kill)
                q.delete();
            else begin
                if (b1.valid_out && b1.ready_in && q.size() > 0) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (b1.valid_in && exp_rdy)
                    q.push_back(mdl(N, b1.in, b1.sel, b1.dir, b1.sgn));
            end
        end
    end

    task automatic drive1(input logic [7:0] x, input logic [2:0] sh, input logic d, input logic sg);
        b1.in = x; b1.sel = sh; b1.dir = d; b1.sgn = sg;
    endtask

    // One op into an empty pipe; checks latency and the literal result.
    task automatic send1(input string nm, input logic [7:0] x, input logic [2:0] sh, input logic d,
                         input logic sg, input logic [7:0] eo, input logic es);
        int k;
        @(posedge clk); #1;
        b1.valid_in = 1'b1; b1.ready_in = 1'b1;
        drive1(x, sh, d, sg);
        @(posedge clk); #1;
        b1.valid_in = 1'b0;
        k = 0;
        while (!b1.valid_out && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_lat"}, 32'(k), 32'(ST - 1));
        chk({nm, "_out"}, 32'(b1.out), 32'(eo));
        chk({nm, "_st"}, 32'(b1.sticky_bit), 32'(es));
    endtask

    task automatic send2(input string nm, input logic [4:0] x, input logic [2:0] sh, input logic d,
                         input logic sg, input logic [4:0] eo, input logic es);
        int k;
        @(posedge clk); #1;
        b2.valid_in = 1'b1; b2.in = x; b2.sel = sh; b2.dir = d; b2.sgn = sg;
        @(posedge clk); #1;
        b2.valid_in = 1'b0;
        k = 0;
        while (!b2.valid_out && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_lat"}, 32'(k), 32'd2);
        chk({nm, "_out"}, 32'(b2.out), 32'(eo));
        chk({nm, "_st"}, 32'(b2.sticky_bit), 32'(es));
    endtask

    initial begin
        int idx, base;
        bit saw_full;
        b1.kill = 0; b1.valid_in = 0; b1.in = '0; b1.sel = '0; b1.dir = 0; b1.sgn = 0; b1.ready_in = 1;
        b2.kill = 0; b2.valid_in = 0; b2.in = '0; b2.sel = '0; b2.dir = 0; b2.sgn = 0; b2.ready_in = 1;

        chk("pin_right", 32'(mdl(8, 8'hB6, 3'd3, 1'b0, 1'b1)), 32'h1F6);
        chk("pin_left",  32'(mdl(8, 8'hC3, 3'd2, 1'b1, 1'b0)), 32'h10C);
        chk("pin_sat",   32'(mdl(5, 8'h01, 3'd7, 1'b0, 1'b0)), 32'h100);

        #12;
        chk("rst_valid", 32'(b1.valid_out), 32'd0);
        chk("rst_out", 32'(b1.out), 32'd0);
        chk("rst_sticky", 32'(b1.sticky_bit), 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        chk_en  = 1'b1;
        #1 chk("rst_ready", 32'(b1.ready_out), 32'd1);

        send1("r_sgn",   8'hB6, 3'd3, 1'b0, 1'b1, 8'hF6, 1'b1);
        send1("l_lost",  8'hC3, 3'd2, 1'b1, 1'b0, 8'h0C, 1'b1);
        send1("l_clean", 8'h03, 3'd2, 1'b1, 1'b0, 8'h0C, 1'b0);
        send1("r_zero",  8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5, 1'b0);
        send1("l_zero",  8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5, 1'b0);
        send1("r_max_s", 8'h80, 3'd7, 1'b0, 1'b1, 8'hFF, 1'b0);
        send1("r_max_z", 8'h81, 3'd7, 1'b0, 1'b0, 8'h01, 1'b1);
        send1("l_max",   8'h01, 3'd7, 1'b1, 1'b0, 8'h80, 1'b0);
        send1("l_max_l", 8'hFF, 3'd7, 1'b1, 1'b0, 8'h80, 1'b1);
        send1("r_mid",   8'h4D, 3'd5, 1'b0, 1'b0, 8'h02, 1'b1);

        send2("n5_sat",   5'h01, 3'd7, 1'b0, 1'b0, 5'h00, 1'b1);
        send2("n5_fill",  5'h00, 3'd7, 1'b0, 1'b1, 5'h1F, 1'b0);
        send2("n5_sgn",   5'h08, 3'd3, 1'b0, 1'b1, 5'h1D, 1'b0);
        send2("n5_left",  5'h1F, 3'd4, 1'b1, 1'b0, 5'h10, 1'b1);

        // Back-pressure: six ops, sink stalled for cycles 3..6.
        @(posedge clk); #1;
        idx = 0; saw_full = 0; base = n_out;
        for (int c = 0; c < 16; c++) begin
            b1.ready_in = !(c >= 3 && c <= 6);
            b1.valid_in = (idx < 6);
            drive1(8'(8'h29 * (idx + 1)), 3'(idx + 1), idx[0], idx[1]);
            @(negedge clk);
            if (b1.valid_in && b1.ready_out) idx++;
            if (!b1.ready_out) saw_full = 1;
            @(posedge clk); #1;
        end
        b1.valid_in = 1'b0;
        chk("bp_accepted", 32'(idx), 32'd6);
        chk("bp_full_seen", 32'(saw_full), 32'd1);
        chk("bp_outputs", 32'(n_out - base), 32'd6);

        // Kill with two ops in flight and a coincident valid_in.
        @(posedge clk); #1;
        b1.ready_in = 1'b0; b1.valid_in = 1'b1; drive1(8'h5A, 3'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive1(8'h3C, 3'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        b1.kill = 1'b1; drive1(8'h77, 3'd3, 1'b0, 1'b1);
        chk("kill_ready", 32'(b1.ready_out), 32'd0);
        @(posedge clk); #1;
        b1.kill = 1'b0; b1.valid_in = 1'b0; b1.ready_in = 1'b1;
        chk("kill_valid", 32'(b1.valid_out), 32'd0);
        base = n_out;
        repeat (6) @(posedge clk);
        #1 chk("kill_stale", 32'(n_out - base), 32'd0);

        // Async reset while an output is being held.
        b1.ready_in = 1'b0; b1.valid_in = 1'b1; drive1(8'hFF, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        b1.valid_in = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(b1.valid_out), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_valid", 32'(b1.valid_out), 32'd0);
        chk("arst_out", 32'(b1.out), 32'd0);
        chk("arst_sticky", 32'(b1.sticky_bit), 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        #1 chk("arst_ready", 32'(b1.ready_out), 32'd1);

        // Random sweep, scoreboard checks every cycle.
        repeat (400) begin
            @(posedge clk); #1;
            b1.valid_in = 1'($urandom_range(0, 1));
            b1.ready_in = ($urandom_range(0, 3) != 0);
            b1.kill     = ($urandom_range(0, 31) == 0);
            drive1(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end
        @(posedge clk); #1;
        b1.valid_in = 1'b0; b1.kill = 1'b0; b1.ready_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
